// File: rtl/periph_bus.sv
// Memory-stage peripheral block: timer (TH/TL/TCON), LEDs, switches, 7-segment
// display and free-running systick, decoded in a 32-byte window at BASE_ADDR.
module periph_bus #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int unsigned LED_W     = 8,
  parameter int unsigned SW_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rd,
  input  logic             wr,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  input  logic [SW_W-1:0]  switch,
  output logic [LED_W-1:0] led,
  output logic [11:0]      digi,
  output logic             irqout
);

  localparam logic [2:0] IDX_TH      = 3'd0;
  localparam logic [2:0] IDX_TL      = 3'd1;
  localparam logic [2:0] IDX_TCON    = 3'd2;
  localparam logic [2:0] IDX_LED     = 3'd3;
  localparam logic [2:0] IDX_SWITCH  = 3'd4;
  localparam logic [2:0] IDX_DIGI    = 3'd5;
  localparam logic [2:0] IDX_SYSTICK = 3'd6;

  logic [31:0]      th_q, th_d;
  logic [31:0]      tl_q, tl_d;
  logic [2:0]       tcon_q, tcon_d;
  logic [LED_W-1:0] led_q, led_d;
  logic [11:0]      digi_q, digi_d;
  logic [31:0]      systick_q, systick_d;
  logic [SW_W-1:0]  sw_meta_q, sw_meta_d;
  logic [SW_W-1:0]  sw_sync_q, sw_sync_d;

  logic [31:0] off_s;
  logic        in_win_s;
  logic [2:0]  idx_s;
  logic        wr_th_s, wr_tl_s, wr_tcon_s, wr_led_s, wr_digi_s;
  logic        tl_max_s, overflow_s;

  // Address decode: offset within the window, byte lanes ignored.
  always_comb begin
    off_s    = addr - BASE_ADDR;
    in_win_s = (off_s[31:5] == 27'd0);
    idx_s    = off_s[4:2];
  end

  // Per-register write strobes; switch, systick and the unused slot decode to none.
  always_comb begin
    wr_th_s   = wr && in_win_s && (idx_s == IDX_TH);
    wr_tl_s   = wr && in_win_s && (idx_s == IDX_TL);
    wr_tcon_s = wr && in_win_s && (idx_s == IDX_TCON);
    wr_led_s  = wr && in_win_s && (idx_s == IDX_LED);
    wr_digi_s = wr && in_win_s && (idx_s == IDX_DIGI);
  end

  // Combinational read mux from current register state.
  always_comb begin
    rdata = 32'd0;
    if (rd && in_win_s) begin
      case (idx_s)
        IDX_TH:      rdata = th_q;
        IDX_TL:      rdata = tl_q;
        IDX_TCON:    rdata = 32'(tcon_q);
        IDX_LED:     rdata = 32'(led_q);
        IDX_SWITCH:  rdata = 32'(sw_sync_q);
        IDX_DIGI:    rdata = 32'(digi_q);
        IDX_SYSTICK: rdata = systick_q;
        default:     rdata = 32'd0;
      endcase
    end else begin
      rdata = 32'd0;
    end
  end

  // Timer next state: a CPU write to TL cancels both the reload and the status set.
  always_comb begin
    tl_max_s   = (tl_q == 32'hFFFF_FFFF);
    overflow_s = tcon_q[0] && tl_max_s && !wr_tl_s;

    th_d = th_q;
    if (wr_th_s) begin
      th_d = wdata;
    end else begin
      th_d = th_q;
    end

    tl_d = tl_q;
    if (wr_tl_s) begin
      tl_d = wdata;
    end else if (tcon_q[0]) begin
      // reload uses the TH value from before any same-cycle TH write
      tl_d = tl_max_s ? th_q : (tl_q + 32'd1);
    end else begin
      tl_d = tl_q;
    end

    tcon_d = tcon_q;
    if (wr_tcon_s) begin
      tcon_d = wdata[2:0];
    end else if (overflow_s && tcon_q[1]) begin
      tcon_d = {1'b1, tcon_q[1:0]};
    end else begin
      tcon_d = tcon_q;
    end
  end

  // Next state for the simple registers, systick and the switch synchronizer.
  always_comb begin
    led_d = led_q;
    if (wr_led_s) begin
      led_d = wdata[LED_W-1:0];
    end else begin
      led_d = led_q;
    end

    digi_d = digi_q;
    if (wr_digi_s) begin
      digi_d = wdata[11:0];
    end else begin
      digi_d = digi_q;
    end

    systick_d = systick_q + 32'd1;
    sw_meta_d = switch;
    sw_sync_d = sw_meta_q;
  end

  // State registers, cleared immediately by the asynchronous reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th_q      <= 32'd0;
      tl_q      <= 32'd0;
      tcon_q    <= 3'd0;
      led_q     <= '0;
      digi_q    <= 12'd0;
      systick_q <= 32'd0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      th_q      <= th_d;
      tl_q      <= tl_d;
      tcon_q    <= tcon_d;
      led_q     <= led_d;
      digi_q    <= digi_d;
      systick_q <= systick_d;
      sw_meta_q <= sw_meta_d;
      sw_sync_q <= sw_sync_d;
    end
  end

  assign led    = led_q;
  assign digi   = digi_q;
  assign irqout = tcon_q[1] & tcon_q[2];

endmodule

// File: tb/tb_periph_bus.sv
// Directed self-checking bench for periph_bus: decode, read/write paths,
// switch synchronizer, timer reload/interrupt precedence and async reset.
module tb_periph_bus;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] A_TH = BASE + 32'h00;
  localparam logic [31:0] A_TL = BASE + 32'h04;
  localparam logic [31:0] A_TC = BASE + 32'h08;
  localparam logic [31:0] A_LD = BASE + 32'h0C;
  localparam logic [31:0] A_SW = BASE + 32'h10;
  localparam logic [31:0] A_DG = BASE + 32'h14;
  localparam logic [31:0] A_ST = BASE + 32'h18;
  localparam logic [31:0] A_NO = BASE + 32'h1C;

  logic        clk;
  logic        reset;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  switch;
  logic [7:0]  led;
  logic [11:0] digi;
  logic        irqout;

  int n_checks = 0;
  int n_fail   = 0;

  periph_bus #(.BASE_ADDR(BASE), .LED_W(8), .SW_W(8)) dut (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .switch(switch), .led(led), .digi(digi), .irqout(irqout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one write; called just after a falling edge, returns after the next one.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    wr = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    #1;
    wr = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    rd = 1'b1; addr = a;
    #1;
    chk(tag, rdata, exp);
    rd = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; rd = 1'b0; wr = 1'b0; addr = 32'd0; wdata = 32'd0; switch = 8'h00;
    #2;
    chk("rst_irq", 32'(irqout), 32'd0);
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_digi", 32'(digi), 32'd0);
    rd_chk("rst_th", A_TH, 32'd0);
    rd_chk("rst_tl", A_TL, 32'd0);
    rd_chk("rst_tcon", A_TC, 32'd0);
    rd_chk("rst_ledr", A_LD, 32'd0);
    rd_chk("rst_sw", A_SW, 32'd0);
    rd_chk("rst_dgr", A_DG, 32'd0);
    rd_chk("rst_st", A_ST, 32'd0);
    @(negedge clk);
    #1;
    reset = 1'b1;

    do_write(A_NO, 32'hDEAD_BEEF);
    rd_chk("unmapped", A_NO, 32'd0);

    // LED / 7-seg truncation, rd=0 gating and read-before-write
    do_write(A_LD, 32'h0000_01A5);
    do_write(A_DG, 32'h000F_FF3A);
    chk("led_out", 32'(led), 32'h0000_00A5);
    chk("digi_out", 32'(digi), 32'h0000_0F3A);
    rd_chk("led_rd", A_LD, 32'h0000_00A5);
    rd_chk("digi_rd", A_DG, 32'h0000_0F3A);
    addr = A_LD; rd = 1'b0; #1;
    chk("rd0_zero", rdata, 32'd0);
    rd = 1'b1; wr = 1'b1; wdata = 32'h0000_0033; #1;
    chk("rdwr_old", rdata, 32'h0000_00A5);
    @(negedge clk); #1;
    wr = 1'b0;
    chk("rdwr_new", rdata, 32'h0000_0033);
    rd = 1'b0;
    do_write(A_ST, 32'h1234_5678);
    do_write(A_SW, 32'hFFFF_FFFF);
    rd_chk("sw_ro", A_SW, 32'd0);

    // switch synchronizer: two rising edges of latency
    switch = 8'h5C;
    idle(1);
    rd_chk("sw_1edge", A_SW, 32'd0);
    idle(1);
    rd_chk("sw_2edge", A_SW, 32'h0000_005C);

    // timer overflow, reload from TH and sticky status
    do_write(A_TH, 32'hFFFF_FFF0);
    do_write(A_TL, 32'hFFFF_FFFE);
    do_write(A_TC, 32'd3);
    rd_chk("tl_start", A_TL, 32'hFFFF_FFFE);
    idle(1);
    rd_chk("tl_max", A_TL, 32'hFFFF_FFFF);
    chk("irq_pre", 32'(irqout), 32'd0);
    idle(1);
    rd_chk("tl_reload", A_TL, 32'hFFFF_FFF0);
    chk("irq_set", 32'(irqout), 32'd1);
    rd_chk("tcon_sts", A_TC, 32'd7);
    idle(1);
    chk("irq_sticky", 32'(irqout), 32'd1);
    // that idle was R+1; clear status lands at R+2
    do_write(A_TC, 32'd3);
    chk("irq_clr", 32'(irqout), 32'd0);
    rd_chk("tl_r2", A_TL, 32'hFFFF_FFF2);
    idle(13);
    rd_chk("tl_r15", A_TL, 32'hFFFF_FFFF);
    chk("irq_r15", 32'(irqout), 32'd0);
    idle(1);
    rd_chk("tl_r16", A_TL, 32'hFFFF_FFF0);
    chk("irq_r16", 32'(irqout), 32'd1);

    // CPU write to TL beats reload and status set
    do_write(A_TC, 32'd0);
    do_write(A_TL, 32'hFFFF_FFFF);
    do_write(A_TC, 32'd3);
    rd_chk("tl_hold", A_TL, 32'hFFFF_FFFF);
    do_write(A_TL, 32'h0000_0010);
    rd_chk("tl_wrwin", A_TL, 32'h0000_0010);
    rd_chk("tcon_nosts", A_TC, 32'd3);
    idle(1);
    rd_chk("tl_inc", A_TL, 32'h0000_0011);

    // irq disabled: reload still happens; TH write in reload cycle uses old TH
    do_write(A_TC, 32'd0);
    do_write(A_TH, 32'h0000_0100);
    do_write(A_TL, 32'hFFFF_FFFF);
    do_write(A_TC, 32'd1);
    do_write(A_TH, 32'h0000_0200);
    rd_chk("tl_oldth", A_TL, 32'h0000_0100);
    rd_chk("th_new", A_TH, 32'h0000_0200);
    rd_chk("tcon_noirq", A_TC, 32'd1);
    chk("irq_dis", 32'(irqout), 32'd0);
    do_write(A_TC, 32'd0);
    idle(2);
    rd_chk("tl_paused", A_TL, 32'h0000_0101);
    do_write(A_TC, 32'd1);
    rd_chk("tl_resume", A_TL, 32'h0000_0101);
    idle(1);
    rd_chk("tl_resume1", A_TL, 32'h0000_0102);

    // async reset mid-count with irqout asserted
    do_write(A_TC, 32'd0);
    do_write(A_TH, 32'd0);
    do_write(A_TL, 32'hFFFF_FFFE);
    do_write(A_TC, 32'd3);
    idle(2);
    chk("irq_before_rst", 32'(irqout), 32'd1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_irq_now", 32'(irqout), 32'd0);
    rd_chk("rst_tl_now", A_TL, 32'd0);
    rd_chk("rst_tc_now", A_TC, 32'd0);
    rd_chk("rst_led_now", A_LD, 32'd0);
    @(negedge clk);
    #1;
    reset = 1'b1;
    rd_chk("st0", A_ST, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      idle(1);
      rd_chk("st_cnt", A_ST, 32'(i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/periph_bus.md
Name: periph_bus

Overview:
- Memory-stage peripheral block that sits directly downstream of the EX-stage ALU.
- Consumes the ALU-computed effective address plus the load/store controls, and decodes the peripheral window at BASE_ADDR.
- Holds the timer (TH/TL/TCON), LED, switch, 7-segment and systick registers.
- Returns read data to the MEM/WB mux and raises the timer interrupt toward the control unit.

Parameters:
BASE_ADDR, 32'h40000000, byte base of the peripheral window
LED_W, 8, LED register width
SW_W, 8, switch input width

Ports:
clk  in  1  the single clock; all state on rising edge
reset  in  1  asynchronous, active-low reset
rd  in  1  load strobe from MEM stage
wr  in  1  store strobe from MEM stage
addr  in  32  byte address (ALU result)
wdata  in  32  store data
rdata  out  32  load data, combinational
switch  in  SW_W  board switches, asynchronous
led  out  LED_W  LED register
digi  out  12  7-seg register: [11:8] anode select, [7:0] segments
irqout  out  1  timer interrupt request

Behaviour:
- Reset (reset=0, immediate, no clock needed): TH=0, TL=0, TCON=0, led=0, digi=0, systick=0, switch synchronizer=0, irqout=0.
- Address decode:
  - addr[1:0] ignored; offset = addr - BASE_ADDR.
  - +0x00 TH rw; +0x04 TL rw; +0x08 TCON[2:0] rw; +0x0C led rw; +0x10 switch ro; +0x14 digi rw; +0x18 systick ro.
  - Any other address: rdata=0, writes ignored.
- Read path:
  - rdata is valid in the same cycle as rd=1 and addr, combinational from current register values.
  - Narrow registers are zero-extended.
  - rd=0 gives rdata=0.
- Write path:
  - Registered on the rising clk edge when wr=1; value visible on the following cycle.
  - Register gets wdata truncated to register width.
  - Writes to switch and systick are ignored.
  - rd and wr asserted together: read returns the pre-write value.
- Switch synchronizer: two-flop. A switch change becomes readable after 2 rising edges.
- Systick: increments every cycle from reset, 32-bit, wraps 0xFFFFFFFF->0.
- Timer:
  - TCON bits: [0]=enable, [1]=irq enable, [2]=irq status.
  - While enable=1, TL increments each cycle.
  - When enable=1 and TL==0xFFFFFFFF: on the next edge TL<=TH (reload, not 0), and if TCON[1]=1 then TCON[2]<=1.
  - TCON[2] is sticky until software writes TCON with bit2=0.
- irqout = TCON[1] & TCON[2], combinational from registers.
- Precedence on simultaneous events:
  - CPU write to TL beats increment/reload that cycle.
  - CPU write to TCON beats status set that cycle (written value wins).
  - CPU write to TH in the reload cycle: TL reloads with the old TH.
- Enable cleared mid-count: TL holds its value; re-enable resumes from that value.
- Reset mid-operation: all state returns to reset values immediately; a pending wr in that cycle is lost.

Test Plan:
- Reset then read each of +0x00..+0x18 -> all rdata=0; irqout=0; write 0xDEADBEEF to +0x1C then read +0x1C -> 0.
- Write led=0x1A5, digi=0xFFF3A; read back -> led=0xA5, rdata 0x000000A5; digi=0xF3A.
- Switch goes 0x00->0x5C at edge k -> read at k+1 returns 0x00, at k+2 returns 0x5C.
- TH=0xFFFFFFF0, TL=0xFFFFFFFE, TCON=3 -> TL=0xFFFFFFFF after 1 cycle, 0xFFFFFFF0 after 2, irqout=1 from then on. Write TCON=3 -> irqout=0 next cycle; next overflow 16 cycles after the reload cycle.
- TL=0xFFFFFFFF with enable=1 and same-cycle wr TL=0x10 -> TL=0x10, no reload, TCON[2] stays 0. TCON=1 (irq disabled) overflow -> reload occurs, irqout stays 0.
- Assert reset low between clock edges while TL counting with irqout=1 -> TL, TCON, irqout go 0 immediately. After release, systick reads 0 on the first cycle, then counts 1,2,3.
